uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_ctrl_if.sv | 50 +++++
 rtl/uart_rx_deser.sv | 36 +++
 rtl/uart_rx_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// UART receive controller shared types and constants.
// Optional parity support is selected by UART_RX_PARITY_EN.
package uart_rx_pkg;

  localparam int EDGES_PER_BIT   = 8;
  localparam int DEF_SAMPLE_EDGE = 6;
  localparam int DEF_DATA_WIDTH  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// UART receive controller signal bundle.
// slave: the controller; master: line, counters and sampler side.
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [3:0]            edge_count;
  logic [4:0]            bit_count;
  logic                  sampled_bit;
  logic                  edge_bit_enable;
  logic                  data_samp_en;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport slave (
    input  RX_IN,
    input  PAR_EN,
    input  PAR_TYP,
    input  edge_count,
    input  bit_count,
    input  sampled_bit,
    output edge_bit_enable,
    output data_samp_en,
    output P_DATA,
    output data_valid,
    output par_err,
    output stp_err
  );

  modport master (
    output RX_IN,
    output PAR_EN,
    output PAR_TYP,
    output edge_count,
    output bit_count,
    output sampled_bit,
    input  edge_bit_enable,
    input  data_samp_en,
    input  P_DATA,
    input  data_valid,
    input  par_err,
    input  stp_err
  );

endinterface

// File: rtl/uart_rx_deser.sv
// Working-word register: writes sampled_bit at bit (bit_count-1).
// Ports: clk/reset, shift_en, bit_count, sampled_bit, word, par_exp.
module uart_rx_deser
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_based_on_prescale,
  input  logic                  asy_reset,
  input  logic                  shift_en,
  input  logic [4:0]            bit_count,
  input  logic                  sampled_bit,
`ifdef UART_RX_PARITY_EN
  input  logic                  par_typ,
  output logic                  par_exp,
`endif
  output logic [DATA_WIDTH-1:0] word
);

  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      word <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (bit_count == 5'(i + 1)) begin
          word[i] <= sampled_bit;
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign par_exp = (^word) ^ par_typ;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame FSM: start check, data, parity, stop, pulses.
// Ports: clk, asy_reset, bus (slave). Macro: UART_RX_PARITY_EN.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SAMPLE_EDGE = DEF_SAMPLE_EDGE
) (
  input  logic          clk_based_on_prescale,
  input  logic          asy_reset,
  uart_rx_ctrl_if.slave bus
);

  rx_state_e             state_q;
  rx_state_e             state_d;
  logic                  tick;
  logic                  ebe;
  logic                  dse;
  logic                  shift_en;
  logic                  load_data;
  logic                  dv_d;
  logic                  dv_q;
  logic                  se_d;
  logic                  se_q;
  logic                  set_err;
  logic                  err_q;
  logic                  frame_go;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] p_data_q;

`ifdef UART_RX_PARITY_EN
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_exp;
  logic                  pe_d;
  logic                  pe_q;
`else
  logic                  unused_par;
  assign unused_par = ^{bus.PAR_EN, bus.PAR_TYP};
`endif

  assign tick = (state_q != IDLE) &&
                (bus.edge_count == 4'(SAMPLE_EDGE));

  assign frame_go = (state_q == IDLE) && !bus.RX_IN;

  uart_rx_deser #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_deser (
    .clk_based_on_prescale (clk_based_on_prescale),
    .asy_reset             (asy_reset),
    .shift_en              (shift_en),
    .bit_count             (bus.bit_count),
    .sampled_bit           (bus.sampled_bit),
`ifdef UART_RX_PARITY_EN
    .par_typ               (par_typ_q),
    .par_exp               (par_exp),
`endif
    .word                  (word)
  );

  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ebe       = 1'b0;
    dse       = 1'b1;
    shift_en  = 1'b0;
    load_data = 1'b0;
    dv_d      = 1'b0;
    se_d      = 1'b0;
    set_err   = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_d      = 1'b0;
`endif
    unique case (1'b1)
      (state_q == IDLE): begin
        ebe = 1'b1;
        dse = 1'b0;
        if (!bus.RX_IN) begin
          state_d = START;
        end
      end
      (state_q == START): begin
        if (tick) begin
          state_d = bus.sampled_bit ? IDLE : DATA;
        end
      end
      (state_q == DATA): begin
        if (tick) begin
          shift_en = 1'b1;
          if (bus.bit_count == 5'(DATA_WIDTH)) begin
`ifdef UART_RX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      (state_q == PARITY): begin
        if (tick) begin
          if (bus.sampled_bit != par_exp) begin
            pe_d    = 1'b1;
            set_err = 1'b1;
          end
          state_d = STOP;
        end
      end
`endif
      (state_q == STOP): begin
        if (tick) begin
          if (!bus.sampled_bit) begin
            se_d = 1'b1;
          end else if (!err_q) begin
            dv_d      = 1'b1;
            load_data = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ebe     = 1'b1;
        dse     = 1'b0;
      end
    endcase
  end

  // Frame-error flag lives for one frame; cleared on the start edge.
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      err_q <= 1'b0;
    end else if (frame_go) begin
      err_q <= 1'b0;
    end else if (set_err) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      dv_q     <= 1'b0;
      se_q     <= 1'b0;
      p_data_q <= '0;
    end else begin
      dv_q <= dv_d;
      se_q <= se_d;
      if (load_data) begin
        p_data_q <= word;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
    if (!asy_reset) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      pe_q <= pe_d;
      if (frame_go) begin
        par_en_q  <= bus.PAR_EN;
        par_typ_q <= bus.PAR_TYP;
      end
    end
  end
  assign bus.par_err = pe_q;
`else
  assign bus.par_err = 1'b0;
`endif

  assign bus.edge_bit_enable = ebe;
  assign bus.data_samp_en    = dse;
  assign bus.P_DATA          = p_data_q;
  assign bus.data_valid      = dv_q;
  assign bus.stp_err         = se_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a modelled edge/bit counter.
// Follows UART_RX_PARITY_EN for the parity scenarios.
module tb_uart_rx_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.DATA_WIDTH(8)) u_if ();

  uart_rx_ctrl #(
    .DATA_WIDTH  (8),
    .SAMPLE_EDGE (6)
  ) dut (
    .clk_based_on_prescale (clk),
    .asy_reset             (rst_n),
    .bus                   (u_if)
  );

  int vectors = 0;
  int miscompares = 0;
  int dv_cnt;
  int pe_cnt;
  int se_cnt;
  logic [7:0] dv_log[$];
  logic [7:0] exp_pdata;
  logic [3:0] ec;
  logic [4:0] bc;

  task automatic clr_mon();
    dv_cnt = 0;
    pe_cnt = 0;
    se_cnt = 0;
    dv_log.delete();
  endtask

  // One clock: counter model plus pulse monitor.
  task automatic step();
    logic ebe;
    ebe = u_if.edge_bit_enable;
    @(posedge clk);
    #1;
    if (ebe !== 1'b0) begin
      ec = '0;
      bc = '0;
    end else if (ec == 4'd7) begin
      ec = '0;
      bc = bc + 5'd1;
    end else begin
      ec = ec + 4'd1;
    end
    u_if.edge_count = ec;
    u_if.bit_count  = bc;
    if (u_if.data_valid === 1'b1) begin
      dv_cnt++;
      dv_log.push_back(u_if.P_DATA);
    end
    if (u_if.par_err === 1'b1) pe_cnt++;
    if (u_if.stp_err === 1'b1) se_cnt++;
  endtask

  task automatic drive_bit(input logic b);
    u_if.RX_IN       = b;
    u_if.sampled_bit = b;
    repeat (8) step();
  endtask

  task automatic idle(input int n);
    u_if.RX_IN       = 1'b1;
    u_if.sampled_bit = 1'b1;
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par,
                            input logic par_bit, input logic stp);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (has_par) drive_bit(par_bit);
    drive_bit(stp);
  endtask

  task automatic chk_counts(input string nm, input int dv,
                            input int pe, input int se);
    vectors++;
    if (dv_cnt !== dv) begin
      miscompares++;
      $display("FAIL %s dv_cnt: got %0d want %0d", nm, dv_cnt, dv);
    end
    vectors++;
    if (pe_cnt !== pe) begin
      miscompares++;
      $display("FAIL %s pe_cnt: got %0d want %0d", nm, pe_cnt, pe);
    end
    vectors++;
    if (se_cnt !== se) begin
      miscompares++;
      $display("FAIL %s se_cnt: got %0d want %0d", nm, se_cnt, se);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    vectors++;
    if (u_if.edge_bit_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ebe: got %b want 1", nm, u_if.edge_bit_enable);
    end
    vectors++;
    if (u_if.data_samp_en !== 1'b0) begin
      miscompares++;
      $display("FAIL %s dse: got %b want 0", nm, u_if.data_samp_en);
    end
    vectors++;
    if (u_if.P_DATA !== 8'h00) begin
      miscompares++;
      $display("FAIL %s P_DATA: got %h want 00", nm, u_if.P_DATA);
    end
    vectors++;
    if ({u_if.data_valid, u_if.par_err, u_if.stp_err} !== 3'b000) begin
      miscompares++;
      $display("FAIL %s pulses: got %b want 000", nm,
               {u_if.data_valid, u_if.par_err, u_if.stp_err});
    end
  endtask

  task automatic chk_pdata(input string nm, input logic [7:0] want);
    vectors++;
    if (u_if.P_DATA !== want) begin
      miscompares++;
      $display("FAIL %s P_DATA: got %h want %h", nm, u_if.P_DATA, want);
    end
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    u_if.RX_IN       = 1'b1;
    u_if.sampled_bit = 1'b1;
    u_if.PAR_EN      = 1'b0;
    u_if.PAR_TYP     = 1'b0;
    ec               = '0;
    bc               = '0;
    u_if.edge_count  = ec;
    u_if.bit_count   = bc;
    clr_mon();
    repeat (3) step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    idle(4);
    chk_counts("reset_idle", 0, 0, 0);
  endtask

  task automatic test_basic();
    u_if.PAR_EN = 1'b0;
    clr_mon();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle(8);
    exp_pdata = 8'hA5;
    chk_counts("basic_A5", 1, 0, 0);
    chk_pdata("basic_A5", exp_pdata);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    u_if.PAR_EN  = 1'b1;
    u_if.PAR_TYP = 1'b0;
    clr_mon();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    idle(8);
    exp_pdata = 8'h3C;
    chk_counts("par_ok", 1, 0, 0);
    chk_pdata("par_ok", exp_pdata);
    clr_mon();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    idle(8);
    chk_counts("par_bad", 0, 1, 0);
    chk_pdata("par_bad", exp_pdata);
    u_if.PAR_TYP = 1'b1;
    clr_mon();
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    idle(8);
    exp_pdata = 8'h07;
    chk_counts("par_odd", 1, 0, 0);
    chk_pdata("par_odd", exp_pdata);
    u_if.PAR_EN  = 1'b0;
    u_if.PAR_TYP = 1'b0;
  endtask
`else
  task automatic test_no_parity();
    u_if.PAR_EN  = 1'b1;
    u_if.PAR_TYP = 1'b1;
    clr_mon();
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
    idle(8);
    exp_pdata = 8'h0F;
    chk_counts("nopar_0F", 1, 0, 0);
    chk_pdata("nopar_0F", exp_pdata);
    u_if.PAR_EN  = 1'b0;
    u_if.PAR_TYP = 1'b0;
  endtask
`endif

  task automatic test_glitch();
    clr_mon();
    u_if.RX_IN       = 1'b0;
    u_if.sampled_bit = 1'b0;
    step();
    vectors++;
    if ({u_if.edge_bit_enable, u_if.data_samp_en} !== 2'b01) begin
      miscompares++;
      $display("FAIL glitch_start ebe/dse: got %b want 01",
               {u_if.edge_bit_enable, u_if.data_samp_en});
    end
    repeat (2) step();
    idle(5);
    vectors++;
    if ({u_if.edge_bit_enable, u_if.data_samp_en} !== 2'b10) begin
      miscompares++;
      $display("FAIL glitch_idle ebe/dse: got %b want 10",
               {u_if.edge_bit_enable, u_if.data_samp_en});
    end
    idle(16);
    chk_counts("glitch", 0, 0, 0);
    chk_pdata("glitch", exp_pdata);
  endtask

  task automatic test_back_to_back();
    clr_mon();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    idle(16);
    chk_counts("stop_err", 0, 0, 1);
    chk_pdata("stop_err", exp_pdata);
    clr_mon();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    send_frame(8'h80, 1'b0, 1'b0, 1'b1);
    idle(8);
    exp_pdata = 8'h80;
    chk_counts("b2b", 2, 0, 0);
    vectors++;
    if (dv_log.size() != 2) begin
      miscompares++;
      $display("FAIL b2b log size: got %0d want 2", dv_log.size());
    end else if (dv_log[0] !== 8'h01 || dv_log[1] !== 8'h80) begin
      miscompares++;
      $display("FAIL b2b order: got %h %h want 01 80",
               dv_log[0], dv_log[1]);
    end
    chk_pdata("b2b", exp_pdata);
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    d = 8'hAA;
    clr_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    u_if.RX_IN       = d[4];
    u_if.sampled_bit = d[4];
    repeat (4) step();
    vectors++;
    if (u_if.data_samp_en !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_frame dse: got %b want 1", u_if.data_samp_en);
    end
    rst_n = 1'b0;
    #2;
    chk_reset_vals("mid_reset");
    repeat (2) step();
    rst_n = 1'b1;
    idle(10);
    chk_counts("mid_reset", 0, 0, 0);
    clr_mon();
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    idle(8);
    exp_pdata = 8'h55;
    chk_counts("after_reset_55", 1, 0, 0);
    chk_pdata("after_reset_55", exp_pdata);
  endtask

  task automatic test_stuck_low();
    clr_mon();
    u_if.RX_IN       = 1'b0;
    u_if.sampled_bit = 1'b0;
    repeat (200) step();
    chk_counts("stuck_low", 0, 0, 2);
    chk_pdata("stuck_low", exp_pdata);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(4);
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    test_no_parity();
`endif
    test_glitch();
    test_back_to_back();
    test_mid_reset();
    test_stuck_low();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
